strassen_seq: RTL

Time-multiplexed 2x2 Strassen matrix-multiply controller. It shares one signed multiplier across the seven Strassen products, issuing one product per cycle. Each product is accumulated into the four output sub-blocks as it is produced. It sits between an operand source and a result sink, both using valid/ready handshakes, and trades six multipliers for seven cycles of latency.

---
 rtl/strassen_seq.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/strassen_seq.sv
// strassen_seq: time-multiplexed 2x2 Strassen matrix multiply.
// One shared signed multiplier computes the seven Strassen products M1..M7,
// one per cycle, and each product is folded into the four result
// accumulators as soon as it is available.
//
// Optional build macro: STRASSEN_SEQ_PIPE_EN
//   defined   - registers the multiplier output; a DRAIN state folds in M7,
//               giving an 8-cycle accept-to-result latency.
//   undefined - multiplier feeds the accumulators combinationally,
//               giving a 7-cycle latency.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// The source may hold in_valid as long as it likes; operands are taken
// only on the accept edge. The result stays on C* with out_valid high
// until the sink returns out_ready.
module strassen_seq #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A11,
  input  logic [WIDTH-1:0]   A12,
  input  logic [WIDTH-1:0]   A21,
  input  logic [WIDTH-1:0]   A22,
  input  logic [WIDTH-1:0]   B11,
  input  logic [WIDTH-1:0]   B12,
  input  logic [WIDTH-1:0]   B21,
  input  logic [WIDTH-1:0]   B22,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] C11,
  output logic [2*WIDTH-1:0] C12,
  output logic [2*WIDTH-1:0] C21,
  output logic [2*WIDTH-1:0] C22,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  localparam int PW = WIDTH + 2;   // pre-add term width (signed)
  localparam int AW = 2 * WIDTH;   // accumulator / result width

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] MUL   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state;
  logic [2:0]       step;
  logic             accept;

  logic [WIDTH-1:0] a11_q, a12_q, a21_q, a22_q;
  logic [WIDTH-1:0] b11_q, b12_q, b21_q, b22_q;
  logic [AW-1:0]    c11_q, c12_q, c21_q, c22_q;

  logic signed [PW-1:0] s1, s2, s3, s4, s5, s6, s8, s9, s10, s11;
  logic signed [PW-1:0] mul_a, mul_b;
  logic signed [AW-1:0] mul_a_x, mul_b_x;
  logic [AW-1:0]        prod;

  logic                 acc_en;
  logic [2:0]           acc_step;
  logic [AW-1:0]        acc_val;

  // Zero-extend an unsigned element into the signed pre-add width.
  function automatic logic signed [PW-1:0] ext(input logic [WIDTH-1:0] v);
    return $signed({2'b00, v});
  endfunction

  // in_ready decodes the registered state only, so it has no path from
  // in_valid or out_ready.
  assign in_ready  = (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign busy      = (state == MUL) || (state == DRAIN);
  assign dbg_state = state;

  assign C11 = c11_q;
  assign C12 = c12_q;
  assign C21 = c21_q;
  assign C22 = c22_q;

  // Pre-add/sub terms from the latched operands; differences may be negative.
  assign s1  = ext(a11_q) + ext(a22_q);
  assign s2  = ext(b11_q) + ext(b22_q);
  assign s3  = ext(a21_q) + ext(a22_q);
  assign s4  = ext(b12_q) - ext(b22_q);
  assign s5  = ext(b21_q) - ext(b11_q);
  assign s6  = ext(a11_q) + ext(a12_q);
  assign s8  = ext(a21_q) - ext(a11_q);
  assign s9  = ext(b11_q) + ext(b12_q);
  assign s10 = ext(a12_q) - ext(a22_q);
  assign s11 = ext(b21_q) + ext(b22_q);

  // Multiplier operand select for the step being issued.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (step)
      3'd0: begin mul_a = s1;         mul_b = s2;         end
      3'd1: begin mul_a = s3;         mul_b = ext(b11_q); end
      3'd2: begin mul_a = ext(a11_q); mul_b = s4;         end
      3'd3: begin mul_a = ext(a22_q); mul_b = s5;         end
      3'd4: begin mul_a = s6;         mul_b = ext(b22_q); end
      3'd5: begin mul_a = s8;         mul_b = s9;         end
      3'd6: begin mul_a = s10;        mul_b = s11;        end
      default: begin mul_a = '0;      mul_b = '0;         end
    endcase
  end

  // Sign-extending to the result width keeps the low AW product bits exact,
  // which is all the modulo-2^AW accumulation needs.
  assign mul_a_x = {{(AW-PW){mul_a[PW-1]}}, mul_a};
  assign mul_b_x = {{(AW-PW){mul_b[PW-1]}}, mul_b};
  assign prod    = mul_a_x * mul_b_x;

`ifdef STRASSEN_SEQ_PIPE_EN
  logic [AW-1:0] prod_q;
  logic [2:0]    pstep_q;
  logic          pvld_q;

  // Product pipeline register: carries the product and the step it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q  <= '0;
      pstep_q <= '0;
      pvld_q  <= 1'b0;
    end else begin
      prod_q  <= prod;
      pstep_q <= step;
      pvld_q  <= (state == MUL);
    end
  end

  assign acc_en   = pvld_q;
  assign acc_step = pstep_q;
  assign acc_val  = prod_q;
`else
  assign acc_en   = (state == MUL);
  assign acc_step = step;
  assign acc_val  = prod;
`endif

  // Control FSM: accept, seven issue steps, optional drain, result hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      step      <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= MUL;
            step  <= '0;
          end
        end
        MUL: begin
          if (step == 3'd6) begin
            step <= '0;
`ifdef STRASSEN_SEQ_PIPE_EN
            state <= DRAIN;
`else
            state     <= DONE;
            out_valid <= 1'b1;
`endif
          end else begin
            step <= step + 3'd1;
          end
        end
`ifdef STRASSEN_SEQ_PIPE_EN
        DRAIN: begin
          state     <= DONE;
          out_valid <= 1'b1;
        end
`endif
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          step      <= '0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Operand latch: captured on the accept edge only.
  always_ff @(posedge clk) begin
    if (rst) begin
      a11_q <= '0; a12_q <= '0; a21_q <= '0; a22_q <= '0;
      b11_q <= '0; b12_q <= '0; b21_q <= '0; b22_q <= '0;
    end else if (accept) begin
      a11_q <= A11; a12_q <= A12; a21_q <= A21; a22_q <= A22;
      b11_q <= B11; b12_q <= B12; b21_q <= B21; b22_q <= B22;
    end
  end

  // Accumulators: cleared on accept, then each product is added/subtracted
  // into the sub-blocks that use it.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      c11_q <= '0;
      c12_q <= '0;
      c21_q <= '0;
      c22_q <= '0;
    end else if (acc_en) begin
      case (acc_step)
        3'd0: begin c11_q <= c11_q + acc_val; c22_q <= c22_q + acc_val; end
        3'd1: begin c21_q <= c21_q + acc_val; c22_q <= c22_q - acc_val; end
        3'd2: begin c12_q <= c12_q + acc_val; c22_q <= c22_q + acc_val; end
        3'd3: begin c11_q <= c11_q + acc_val; c21_q <= c21_q + acc_val; end
        3'd4: begin c11_q <= c11_q - acc_val; c12_q <= c12_q + acc_val; end
        3'd5: begin c22_q <= c22_q + acc_val; end
        3'd6: begin c11_q <= c11_q + acc_val; end
        default: begin end
      endcase
    end
  end

endmodule
